// File: rtl/master_package.sv
// Shared AHB-Lite bus types used by the master and the ahb_lite_slave_mem responder,
// plus the slave FSM state encoding and the byte-lane decode helper.
package master_package;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } HTRANS_E;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } HSIZE_E;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } HBURST_E;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } HRESP_E;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    // Little-endian lane enables for a transfer of size sz at byte offset a.
    function automatic logic [3:0] lane_mask(input HSIZE_E sz, input logic [1:0] a);
        case (sz)
            HSIZE_BYTE: return 4'b0001 << a;
            HSIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_ram.sv
// Byte-lane register file for ahb_lite_slave_mem: per-lane synchronous write,
// synchronous clear, asynchronous word read.
module ahb_lite_slave_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] r_lane [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int i = 0; i < DEPTH; i++) r_lane[i] <= '0;
            end else if (i_we[b]) begin
                r_lane[i_addr] <= i_wdata[8*b +: 8];
            end
        end

        assign o_rdata[8*b +: 8] = r_lane[i_addr];
    end
endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave fronting a word memory. Define AHB_SLAVE_WAIT_STATES_EN to insert
// WAIT_CYCLES wait states per legal transfer; otherwise every transfer is zero-wait.
module ahb_lite_slave_mem
    import master_package::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    input  HSIZE_E      i_hsize,
    input  HBURST_E     i_hburst,
    input  HTRANS_E     i_htrans,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output HRESP_E      o_hresp,
    output logic [31:0] o_hrdata
);
    localparam int AW = $clog2(MEM_DEPTH);

    slave_state_e  r_state;
    logic          r_hreadyout;
    HRESP_E        r_hresp;
    logic [AW+1:0] r_addr;
    logic          r_write;
    HSIZE_E        r_size;
`ifdef AHB_SLAVE_WAIT_STATES_EN
    logic [3:0]    r_cnt;
`endif

    logic        w_accept;
    logic        w_legal;
    logic [3:0]  w_we;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_accept = i_hsel && i_hready &&
                      (i_htrans == TRANS_NONSEQ || i_htrans == TRANS_SEQ);

    assign w_legal = (i_haddr[31:2] < 30'(MEM_DEPTH)) && (i_hsize <= HSIZE_WORD)
                  && !((i_hsize == HSIZE_HALF) && i_haddr[0])
                  && !((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00));

    // Burst type is irrelevant: every beat carries its own address.
`ifdef AHB_SLAVE_WAIT_STATES_EN
    assign w_unused = ^i_hburst;
`else
    assign w_unused = ^{i_hburst, 4'(WAIT_CYCLES)};
`endif

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= HSIZE_BYTE;
`ifdef AHB_SLAVE_WAIT_STATES_EN
            r_cnt       <= 4'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    if (w_accept) begin
                        r_addr  <= i_haddr[AW+1:0];
                        r_write <= i_hwrite;
                        r_size  <= i_hsize;
                        if (!w_legal) begin
                            r_state     <= ST_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end
`ifdef AHB_SLAVE_WAIT_STATES_EN
                        else if (WAIT_CYCLES != 0) begin
                            r_state     <= ST_WAIT;
                            r_hreadyout <= 1'b0;
                            r_cnt       <= 4'(WAIT_CYCLES);
                        end
`endif
                        else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
`ifdef AHB_SLAVE_WAIT_STATES_EN
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= ST_DATA;
                        r_hreadyout <= 1'b1;
                    end
                end
`endif
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // The write lands on the edge closing ST_DATA, so a read in the next data phase sees it.
    assign w_we = (r_state == ST_DATA && r_write) ? lane_mask(r_size, r_addr[1:0]) : 4'b0000;

    ahb_lite_slave_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_hclk),
        .i_rst   (i_hreset),
        .i_we    (w_we),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (i_hwdata),
        .o_rdata (w_rdata)
    );

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_hrdata    = (r_state == ST_DATA && !r_write) ? w_rdata : 32'h0;
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Self-checking bench for ahb_lite_slave_mem: cycle-level response model plus directed
// and randomized pipelined traffic; honours AHB_SLAVE_WAIT_STATES_EN like the DUT.
module tb_ahb_lite_slave_mem;
    import master_package::*;

    localparam int DEPTH = 256;
    localparam int WC    = 2;
`ifdef AHB_SLAVE_WAIT_STATES_EN
    localparam int EW = WC;
`else
    localparam int EW = 0;
`endif

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic        force_low = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    HSIZE_E      hsize = HSIZE_BYTE;
    HBURST_E     hburst = HBURST_SINGLE;
    HTRANS_E     htrans = TRANS_IDLE;
    logic        hready_bus;
    logic        hreadyout;
    HRESP_E      hresp;
    logic [31:0] hrdata;

    int checks = 0;
    int failures = 0;

    assign hready_bus = force_low ? 1'b0 : hreadyout;

    ahb_lite_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_htrans(htrans),
        .i_hwdata(hwdata), .i_hready(hready_bus), .o_hreadyout(hreadyout),
        .o_hresp(hresp), .o_hrdata(hrdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of expected per-cycle responses, one slot per bus cycle.
    typedef struct {
        bit          rdy;
        bit          err;
        bit          fin;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  sz;
    } slot_t;

    slot_t       mq[$];
    logic [31:0] mm [DEPTH];
    bit          started = 0;

    function automatic slot_t mk(bit r, bit e, bit f, bit w, logic [31:0] a, logic [2:0] s);
        slot_t t;
        t.rdy = r; t.err = e; t.fin = f; t.wr = w; t.addr = a; t.sz = s;
        return t;
    endfunction

    function automatic bit legal(logic [31:0] a, logic [2:0] sz);
        if ((a >> 2) >= 32'(DEPTH)) return 0;
        if (sz > 3'd2) return 0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    always @(posedge clk) begin
        bit          rdy;
        slot_t       s;
        logic [31:0] b;
        int          w, ln;
        started = 1;
        if (hreset) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        end else begin
            rdy = 1;
            if (mq.size() > 0) begin
                s = mq.pop_front();
                rdy = s.rdy;
                if (s.fin && s.wr)
                    for (int k = 0; k < (1 << s.sz); k++) begin
                        b  = s.addr + 32'(k);
                        w  = int'(b >> 2);
                        ln = int'(b[1:0]);
                        mm[w][ln*8 +: 8] = hwdata[ln*8 +: 8];
                    end
            end
            if (rdy && hsel && !force_low && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ)) begin
                if (!legal(haddr, hsize)) begin
                    mq.push_back(mk(0, 1, 0, 0, 0, 0));
                    mq.push_back(mk(1, 1, 0, 0, 0, 0));
                end else begin
                    for (int i = 0; i < EW; i++) mq.push_back(mk(0, 0, 0, 0, 0, 0));
                    mq.push_back(mk(1, 0, 1, hwrite, haddr, hsize));
                end
            end
        end
    end

    always @(negedge clk) begin
        bit          er, ee;
        logic [31:0] ed;
        if (started) begin
            er = 1; ee = 0; ed = 32'h0;
            if (mq.size() > 0) begin
                er = mq[0].rdy;
                ee = mq[0].err;
                if (mq[0].fin && !mq[0].wr) ed = mm[int'(mq[0].addr >> 2)];
            end
            chk("hreadyout", 32'(hreadyout), 32'(er));
            chk("hresp", 32'(hresp == HRESP_ERROR), 32'(ee));
            chk("hrdata", hrdata, ed);
        end
    end

    // Pipelined master driver.
    typedef struct {
        bit          sel;
        logic [1:0]  tr;
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] d;
    } xf_t;

    xf_t         tq[$];
    logic [31:0] last_rdata = 32'h0;
    int          last_waits = 0;
    bit          last_err = 0;
    int          run_cyc = 0;

    task automatic push(bit sel, logic [1:0] tr, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] d);
        xf_t x;
        x.sel = sel; x.tr = tr; x.wr = wr; x.a = a; x.sz = sz; x.d = d;
        tq.push_back(x);
    endtask

    task automatic run();
        bit          dp;
        logic [31:0] dd;
        int          waits, n;
        dp = 0; dd = 32'h0; waits = 0; n = 0;
        while (tq.size() > 0 || dp) begin
            if (tq.size() > 0) begin
                hsel = tq[0].sel; htrans = HTRANS_E'(tq[0].tr); hwrite = tq[0].wr;
                haddr = tq[0].a; hsize = HSIZE_E'(tq[0].sz); hburst = HBURST_INCR;
            end else begin
                hsel = 1'b0; htrans = TRANS_IDLE;
            end
            hwdata = dp ? dd : $urandom();
            @(posedge clk);
            n++;
            if (dp && !hready_bus) waits++;
            if (hready_bus) begin
                if (dp) begin
                    last_rdata = hrdata; last_err = (hresp == HRESP_ERROR); last_waits = waits;
                end
                dp = 0; waits = 0;
                if (tq.size() > 0) begin
                    if (tq[0].sel && tq[0].tr[1]) begin dp = 1; dd = tq[0].d; end
                    void'(tq.pop_front());
                end
            end
            #1;
            if (n > 400) begin
                checks++; failures++;
                $display("FAIL run_timeout actual=%0d cycles required<=400", n);
                tq.delete(); dp = 0;
            end
        end
        hsel = 1'b0; htrans = TRANS_IDLE;
        run_cyc = n;
    endtask

    task automatic rd(input logic [31:0] a);
        push(1, 2'b10, 0, a, 3'd2, 32'h0); run();
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        push(1, 2'b10, 1, a, sz, d); run();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] a, low;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp == HRESP_ERROR), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        hreset = 1'b0;

        rd(32'h0);             chk("rd_0_after_reset", last_rdata, 32'h0);
        wr(32'h10, 3'd2, 32'hDA1A3EAD);
        chk("wr_wait_states", 32'(last_waits), 32'(EW));
        rd(32'h10);            chk("rd_word", last_rdata, 32'hDA1A3EAD);
        wr(32'h13, 3'd0, 32'hEA000000);
        rd(32'h10);            chk("rd_after_byte", last_rdata, 32'hEA1A3EAD);
        wr(32'h10, 3'd1, 32'h000002EA);
        rd(32'h10);            chk("rd_after_half", last_rdata, 32'hEA1A02EA);

        push(1, 2'b10, 1, 32'h20, 3'd1, 32'h00001111);
        push(1, 2'b11, 1, 32'h22, 3'd1, 32'h22220000);
        push(1, 2'b11, 1, 32'h24, 3'd1, 32'h00003333);
        push(1, 2'b11, 1, 32'h26, 3'd1, 32'h44440000);
        run();
        chk("burst_cycles", 32'(run_cyc), 32'(4 * (EW + 1) + 1));
        chk("model_word_20", mm[8], 32'h22221111);
        rd(32'h20);            chk("rd_burst_20", last_rdata, 32'h22221111);
        rd(32'h24);            chk("rd_burst_24", last_rdata, 32'h44443333);

        rd(32'(DEPTH * 4));
        chk("err_oob_resp", 32'(last_err), 32'd1);
        chk("err_oob_len", 32'(last_waits), 32'd1);
        wr(32'h0, 3'd2, 32'h12345678);
        wr(32'h2, 3'd2, 32'hFFFFFFFF);
        chk("err_misalign_resp", 32'(last_err), 32'd1);
        rd(32'h0);             chk("err_no_write", last_rdata, 32'h12345678);

        push(1, 2'b10, 1, 32'h40, 3'd2, 32'hAAAA5555);
        push(1, 2'b01, 0, 32'h44, 3'd2, 32'h0);
        push(1, 2'b11, 1, 32'h44, 3'd2, 32'h5555AAAA);
        run();
        rd(32'h40);            chk("busy_rd_40", last_rdata, 32'hAAAA5555);
        rd(32'h44);            chk("busy_rd_44", last_rdata, 32'h5555AAAA);

        push(0, 2'b10, 1, 32'h34, 3'd2, 32'hCAFEF00D); run();
        rd(32'h34);            chk("nosel_ignored", last_rdata, 32'h0);
        force_low = 1'b1; hsel = 1'b1; htrans = TRANS_NONSEQ; hwrite = 1'b1;
        haddr = 32'h30; hsize = HSIZE_WORD;
        repeat (2) @(posedge clk);
        #1;
        hsel = 1'b0; htrans = TRANS_IDLE; force_low = 1'b0; hwdata = 32'hDEADDEAD;
        @(posedge clk);
        #1;
        rd(32'h30);            chk("hready_low_ignored", last_rdata, 32'h0);

        wr(32'h50, 3'd2, 32'h11112222);
        hsel = 1'b1; htrans = TRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h50; hsize = HSIZE_WORD;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = TRANS_IDLE; hwdata = 32'h99999999; hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
        rd(32'h50);            chk("midrst_dropped", last_rdata, 32'h0);

        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < 10; j++) begin
                r  = $urandom_range(0, 9);
                tr = (r < 5) ? 2'b10 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b01;
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                a  = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 15));
                if ($urandom_range(0, 9) < 7)
                    low = (sz == 3'd0) ? 32'($urandom_range(0, 3)) :
                          (sz == 3'd1) ? 32'(2 * $urandom_range(0, 1)) : 32'h0;
                else
                    low = 32'($urandom_range(0, 3));
                push($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)),
                     (a << 2) + low, sz, $urandom());
            end
            run();
        end
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
